// File: rtl/dec_to_bin_enc_pkg.sv
// Shared types and constants for the keypad digit encoder.
package dec_to_bin_pkg;

  localparam int DIGIT_W  = 4;
  localparam int NUM_KEYS = 10;

  typedef logic [DIGIT_W-1:0]  digit_t;
  // Bit i carries key i (bit 0 = key zero ... bit 9 = key nine).
  typedef logic [NUM_KEYS-1:0] keys_t;

  localparam digit_t DIG_0 = 4'd0;
  localparam digit_t DIG_1 = 4'd1;
  localparam digit_t DIG_2 = 4'd2;
  localparam digit_t DIG_3 = 4'd3;
  localparam digit_t DIG_4 = 4'd4;
  localparam digit_t DIG_5 = 4'd5;
  localparam digit_t DIG_6 = 4'd6;
  localparam digit_t DIG_7 = 4'd7;
  localparam digit_t DIG_8 = 4'd8;
  localparam digit_t DIG_9 = 4'd9;

endpackage

// File: rtl/dec_to_bin_enc_if.sv
// Keypad-side bundle: ten key lines towards the encoder, digit/status back.
interface dec_to_bin_enc_if;
  import dec_to_bin_pkg::*;

  keys_t  keys;
  digit_t res;
  logic   valid;
  logic   press;
  logic   err;

  // Keypad front end drives keys and consumes the encoded digit.
  modport master (output keys, input res, valid, press, err);
  // Encoder side.
  modport slave  (input keys, output res, valid, press, err);

endinterface

// File: rtl/dec_to_bin_enc_onehot.sv
// Combinational one-hot (ten key) to binary digit converter with
// single-key and multi-key detection.
module onehot10_to_bin
  import dec_to_bin_pkg::*;
(
  input  keys_t  keys_i,
  output digit_t code_o,
  output logic   single_o,
  output logic   multi_o
);

  logic [DIGIT_W-1:0] cnt;

  // Encode the lowest set key and count how many keys are set.
  always_comb begin
    code_o = DIG_0;
    cnt    = '0;
    for (int unsigned i = NUM_KEYS; i > 0; i--) begin
      if (keys_i[i-1]) begin
        code_o = digit_t'(i-1);
        cnt    = cnt + 1'b1;
      end
    end
    single_o = (cnt == 4'd1);
    multi_o  = (cnt > 4'd1);
  end

endmodule

// File: rtl/dec_to_bin_enc.sv
// Registered keypad encoder: ten decimal key lines -> 4-bit digit code with
// valid / press-strobe / multi-key error flags.
// Optional build macro: DEC_TO_BIN_INPUT_SYNC_EN (2-flop input synchronizer).
module dec_to_bin_enc
  import dec_to_bin_pkg::*;
#(
  parameter digit_t RESET_DIGIT = DIG_0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   zero,
  input  logic   one,
  input  logic   two,
  input  logic   three,
  input  logic   four,
  input  logic   five,
  input  logic   six,
  input  logic   seven,
  input  logic   eight,
  input  logic   nine,
  output digit_t res,
  output logic   valid,
  output logic   press,
  output logic   err
);

  keys_t  keys_raw;
  keys_t  keys_s;
  digit_t code;
  logic   single;
  logic   multi;

  digit_t res_q,   res_d;
  logic   valid_q, valid_d;
  logic   press_q, press_d;
  logic   err_q,   err_d;
  keys_t  prev_q,  prev_d;

  assign keys_raw = {nine, eight, seven, six, five, four, three, two, one, zero};

`ifdef DEC_TO_BIN_INPUT_SYNC_EN
  keys_t sync1_q, sync2_q;

  // Two-stage synchronizer on every key line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
    end
  end

  assign keys_s = sync2_q;
`else
  assign keys_s = keys_raw;
`endif

  onehot10_to_bin u_enc (
    .keys_i   (keys_s),
    .code_o   (code),
    .single_o (single),
    .multi_o  (multi)
  );

  // Next-state: digit only captured on a clean single key; a press is any
  // single-key sample that differs from the previous sampled key pattern.
  always_comb begin
    res_d   = res_q;
    valid_d = single;
    err_d   = multi;
    press_d = single && (prev_q != keys_s);
    prev_d  = keys_s;
    if (single) begin
      res_d = code;
    end
  end

  // Output and previous-key registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= RESET_DIGIT;
      valid_q <= 1'b0;
      press_q <= 1'b0;
      err_q   <= 1'b0;
      prev_q  <= '0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
      press_q <= press_d;
      err_q   <= err_d;
      prev_q  <= prev_d;
    end
  end

  assign res   = res_q;
  assign valid = valid_q;
  assign press = press_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dec_to_bin_enc.sv
// Randomized + directed bench for dec_to_bin_enc against a behavioural model.
module tb_dec_to_bin_enc;
  import dec_to_bin_pkg::*;

`ifdef DEC_TO_BIN_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dec_to_bin_enc_if kif ();

  dec_to_bin_enc #(.RESET_DIGIT(DIG_0)) dut (
    .clk   (clk),
    .rst   (rst),
    .zero  (kif.keys[0]),
    .one   (kif.keys[1]),
    .two   (kif.keys[2]),
    .three (kif.keys[3]),
    .four  (kif.keys[4]),
    .five  (kif.keys[5]),
    .six   (kif.keys[6]),
    .seven (kif.keys[7]),
    .eight (kif.keys[8]),
    .nine  (kif.keys[9]),
    .res   (kif.res),
    .valid (kif.valid),
    .press (kif.press),
    .err   (kif.err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  keys_t  hist[$];
  keys_t  m_prev;
  int     m_res;
  bit     m_valid, m_press, m_err;
  int     press_seen;
  int     err_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < LAT - 1; i++) hist.push_back('0);
    m_prev  = '0;
    m_res   = 0;
    m_valid = 0;
    m_press = 0;
    m_err   = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".res"},   32'(kif.res),   32'(m_res));
    check({tag, ".valid"}, 32'(kif.valid), 32'(m_valid));
    check({tag, ".press"}, 32'(kif.press), 32'(m_press));
    check({tag, ".err"},   32'(kif.err),   32'(m_err));
  endtask

  // Apply a key pattern, clock once, advance the model and compare.
  task automatic step(input keys_t k, input string tag);
    keys_t eff;
    int    n;
    kif.keys = k;
    @(posedge clk);
    #1;
    hist.push_back(k);
    eff = hist.pop_front();
    n = $countones(eff);
    if (n == 1) begin
      for (int i = 0; i < NUM_KEYS; i++) if (eff[i]) m_res = i;
      m_press = (eff != m_prev);
      m_valid = 1;
      m_err   = 0;
    end else begin
      m_valid = 0;
      m_press = 0;
      m_err   = (n >= 2);
    end
    m_prev = eff;
    check_outputs(tag);
    if (kif.press) press_seen++;
    if (kif.err) err_seen++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  function automatic keys_t key(input int d);
    keys_t k;
    k = '0;
    k[d] = 1'b1;
    return k;
  endfunction

  initial begin
    int first;
    keys_t k, last;

    kif.keys = '0;
    rst = 1'b0;
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) step('0, "idle");

    // Single press and release.
    press_seen = 0;
    for (int i = 0; i < 5; i++) step(key(0), "hold0");
    for (int i = 0; i < LAT + 2; i++) step('0, "rel0");
    check("press_once0", 32'(press_seen), 32'd1);

    // Back-to-back keys, then gapless 1 -> 3 with an idle gap after.
    press_seen = 0;
    for (int i = 0; i < 5; i++) step(key(0), "b2b0");
    for (int i = 0; i < 3; i++) step(key(1), "b2b1");
    for (int i = 0; i < 3; i++) step(key(3), "b2b3");
    step('0, "gap");
    for (int i = 0; i < LAT + 1; i++) step('0, "drain");
    check("press_b2b", 32'(press_seen), 32'd3);

    // Sweep every key alone.
    press_seen = 0;
    err_seen   = 0;
    for (int d = 0; d < NUM_KEYS; d++) begin
      step(key(d), "sweep");
      step(key(d), "sweep");
      for (int i = 0; i < LAT; i++) step('0, "sweep_idle");
      check("sweep_res", 32'(kif.res), 32'(d));
    end
    check("sweep_press", 32'(press_seen), 32'd10);
    check("sweep_err",   32'(err_seen),   32'd0);

    // Multi-key, then drop nine.
    for (int i = 0; i < 3; i++) step(key(4) | key(9), "multi");
    check("multi_hold_res", 32'(kif.res), 32'd9);
    for (int i = 0; i < 3; i++) step(key(4), "drop9");
    check("drop9_res", 32'(kif.res), 32'd4);

    // Latency of a fresh press.
    for (int i = 0; i < LAT + 1; i++) step('0, "lat_idle");
    first = -1;
    for (int i = 1; i <= LAT + 3; i++) begin
      step(key(5), "lat5");
      if (kif.press && first < 0) first = i;
    end
    check("latency", 32'(first), 32'(LAT));

    // Asynchronous reset while seven is held.
    for (int i = 0; i < LAT + 2; i++) step(key(7), "hold7");
    check("pre_rst_valid", 32'(kif.valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    #8;
    rst = 1'b0;

    // Randomized traffic.
    last = '0;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: k = '0;
        1: k = key($urandom_range(0, 9));
        2: k = last;
        default: k = keys_t'($urandom);
      endcase
      step(k, "rand");
      last = k;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
